wakeup_net: RTL
===============

WAKEUP_NET -- requirements
Module: wakeup_net

Interface
REQ-001 Parameter ISSUE_NUM, 4, number of issue ports and tag buses.
REQ-002 Parameter PRF_WIDTH, 6, physical register tag width.
REQ-003 Parameter IQ_DEPTH, 16, issue-queue entries tracked.
REQ-004 Parameter MC_PORT, 2, index of the multi-cycle (mul/div) port.
REQ-005 Parameter MC_LAT, 32, multi-cycle execution latency in cycles; legal range 2..255.
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 flush  in  1  pipeline squash.
REQ-009 grant  in  ISSUE_NUM  arbiter grant per port.
REQ-010 grant_prd  in  ISSUE_NUM x PRF_WIDTH  destination tag of the granted instruction.
REQ-011 grant_prd_v  in  ISSUE_NUM  granted instruction writes a destination.
REQ-012 alloc_v  in  IQ_DEPTH  entry written this cycle.
REQ-013 alloc_prs1, alloc_prs2  in  IQ_DEPTH x PRF_WIDTH  source tags of the allocated entry.
REQ-014 alloc_rdy1, alloc_rdy2  in  IQ_DEPTH  initial readiness from the busy table.
REQ-015 iq_prs1, iq_prs2  in  IQ_DEPTH x PRF_WIDTH  stored source tags of resident entries.
REQ-016 prs1_rdy, prs2_rdy  out  IQ_DEPTH  source ready per entry.
REQ-017 wake_v  out  ISSUE_NUM  tag bus valid.
REQ-018 wake_tag  out  ISSUE_NUM x PRF_WIDTH  tag bus value.
REQ-019 mc_ready  out  1  MC_PORT may be granted this cycle.
REQ-020 mc_done  out  1  one-cycle pulse in the final multi-cycle execution cycle.

Function
REQ-021 A fast port p (p != MC_PORT) shall drive wake_v[p] = grant[p] & grant_prd_v[p] & (grant_prd[p] != 0) and wake_tag[p] = grant_prd[p], combinationally, in the grant cycle.
REQ-022 The MC FSM shall have two states, IDLE and BUSY, plus an 8-bit counter cnt.
REQ-023 IDLE with grant[MC_PORT] shall go to BUSY with cnt=1 and latch grant_prd[MC_PORT] and grant_prd_v[MC_PORT].
REQ-024 In BUSY, cnt shall increment each cycle; when cnt == MC_LAT-1, wake_v[MC_PORT]=latched valid & (latched tag != 0), wake_tag[MC_PORT]=latched tag, and mc_done=1.
REQ-025 A grant in cycle T shall therefore broadcast in cycle T+MC_LAT-1, so a dependent can issue in cycle T+MC_LAT.
REQ-026 mc_ready = IDLE | (BUSY & cnt == MC_LAT-1).
REQ-027 A grant in the final cycle shall restart BUSY with cnt=1 and new latched tag; otherwise the final cycle returns to IDLE.
REQ-028 grant[MC_PORT] while mc_ready=0 shall be ignored, with no state change.
REQ-029 In IDLE, wake_v[MC_PORT]=0 and mc_done=0.
REQ-030 hit1[i] shall be the OR over all buses of (wake_v[j] & wake_tag[j] == tag); tag is alloc_prs1[i] if alloc_v[i], else iq_prs1[i]. hit2 is the same for source 2.
REQ-031 rdy1_q[i] shall load alloc_rdy1[i] | hit1[i] | (alloc_prs1[i]==0) on alloc_v[i]; otherwise it is set when hit1[i] and is sticky. The same rule applies to source 2.
REQ-032 prs1_rdy[i] = rdy1_q[i] | hit1[i], a same-cycle bypass enabling back-to-back issue. The same rule applies to source 2.
REQ-033 Multiple buses matching one tag shall be ORed with no error.
REQ-034 flush shall force the FSM to IDLE with cnt=0, clear all rdy_q, and suppress all wake_v that cycle.
REQ-035 flush shall take priority over grant and alloc in the same cycle.

Reset
REQ-036 rst shall asynchronously force IDLE, cnt=0, latched tag/valid=0, and all rdy_q=0.
REQ-037 During reset, all outputs shall be 0 except mc_ready=1.
REQ-038 Reset mid-operation shall abandon any in-flight MC op without broadcast.

Structure
REQ-039 Package wakeup_pkg shall hold the default PRF_WIDTH, ISSUE_NUM and IQ_DEPTH values and the mc_state_e enum (IDLE, BUSY).
REQ-040 Sub-module wakeup_match shall hold one entry's two-source CAM compare against ISSUE_NUM buses and be instantiated IQ_DEPTH times.

Verification
REQ-041 Fast wake: alloc entry 3 with prs1=9, rdy1=0; later grant[0], prd=9, v=1 -> prs1_rdy[3]=1 the same cycle, and it stays 1 afterward.
REQ-042 Tag 0 and no-dest: grant[1] with prd=0, or prd_v=0 -> wake_v[1]=0 and no entry woken.
REQ-043 MC latency with MC_LAT=4: grant[2], prd=17 at cycle T -> mc_ready=0 at T+1..T+2; wake_v[2], tag 17, and mc_done at T+3; IDLE at T+4.
REQ-044 MC back-to-back: second grant[2], prd=20 at T+3 -> broadcast of 20 at T+6; a grant at T+1 is ignored.
REQ-045 Alloc/wake collision: alloc entry 5 prs2=12, rdy2=0, in the same cycle as a wake of 12 -> prs2_rdy[5]=1 that cycle and after.
REQ-046 Flush and reset: flush at T+2 of an MC op -> no wake at T+3, mc_ready=1 at T+3, all prs_rdy=0. Async rst mid-op -> outputs reset immediately.

Source files
------------

// File: rtl/wakeup_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : wakeup_pkg                                             |
// | Brief   : Shared defaults and FSM state type for the wakeup net. |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
package wakeup_pkg;

  localparam int DEF_ISSUE_NUM = 4;
  localparam int DEF_PRF_WIDTH = 6;
  localparam int DEF_IQ_DEPTH  = 16;
  localparam int MC_CNT_W      = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mc_state_e;

endpackage
`default_nettype wire

// File: rtl/wakeup_match.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : wakeup_match                                           |
// | Brief   : One issue-queue entry's two-source tag CAM against all |
// |           broadcast buses; any matching bus raises the hit.      |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module wakeup_match
  import wakeup_pkg::*;
#(
  parameter int ISSUE_NUM = DEF_ISSUE_NUM,
  parameter int PRF_WIDTH = DEF_PRF_WIDTH
) (
  input  logic [ISSUE_NUM-1:0]           wake_v,
  input  logic [ISSUE_NUM*PRF_WIDTH-1:0] wake_tag,
  input  logic [PRF_WIDTH-1:0]           tag1,
  input  logic [PRF_WIDTH-1:0]           tag2,
  output logic                           hit1,
  output logic                           hit2
);

  // OR-reduce the per-bus compares; several buses hitting one tag is harmless
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int j = 0; j < ISSUE_NUM; j++) begin
      if (wake_v[j] && (wake_tag[j*PRF_WIDTH +: PRF_WIDTH] == tag1)) hit1 = 1'b1;
      if (wake_v[j] && (wake_tag[j*PRF_WIDTH +: PRF_WIDTH] == tag2)) hit2 = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/wakeup_net.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : wakeup_net                                             |
// | Brief   : Tag broadcast from issue ports (fast ports in the      |
// |           grant cycle, one multi-cycle port delayed by MC_LAT-1) |
// |           and per-entry source readiness tracking with bypass.   |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module wakeup_net
  import wakeup_pkg::*;
#(
  parameter int ISSUE_NUM = DEF_ISSUE_NUM,
  parameter int PRF_WIDTH = DEF_PRF_WIDTH,
  parameter int IQ_DEPTH  = DEF_IQ_DEPTH,
  parameter int MC_PORT   = 2,
  parameter int MC_LAT    = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [ISSUE_NUM-1:0]           grant,
  input  logic [ISSUE_NUM*PRF_WIDTH-1:0] grant_prd,
  input  logic [ISSUE_NUM-1:0]           grant_prd_v,
  input  logic [IQ_DEPTH-1:0]            alloc_v,
  input  logic [IQ_DEPTH*PRF_WIDTH-1:0]  alloc_prs1,
  input  logic [IQ_DEPTH*PRF_WIDTH-1:0]  alloc_prs2,
  input  logic [IQ_DEPTH-1:0]            alloc_rdy1,
  input  logic [IQ_DEPTH-1:0]            alloc_rdy2,
  input  logic [IQ_DEPTH*PRF_WIDTH-1:0]  iq_prs1,
  input  logic [IQ_DEPTH*PRF_WIDTH-1:0]  iq_prs2,
  output logic [IQ_DEPTH-1:0]            prs1_rdy,
  output logic [IQ_DEPTH-1:0]            prs2_rdy,
  output logic [ISSUE_NUM-1:0]           wake_v,
  output logic [ISSUE_NUM*PRF_WIDTH-1:0] wake_tag,
  output logic                           mc_ready,
  output logic                           mc_done
);

  // Count value of the final execution cycle, when the result tag is broadcast
  localparam logic [MC_CNT_W-1:0] LAST_CNT = MC_CNT_W'(MC_LAT - 1);

  mc_state_e             state;
  logic [MC_CNT_W-1:0]   cnt;
  logic                  last;     // registered (state == BUSY && cnt == LAST_CNT)
  logic [PRF_WIDTH-1:0]  lat_tag;
  logic                  lat_v;
  logic                  wake_en;
  logic                  mc_grant;
  logic [IQ_DEPTH-1:0]   hit1;
  logic [IQ_DEPTH-1:0]   hit2;
  logic [IQ_DEPTH-1:0]   rdy1_q;
  logic [IQ_DEPTH-1:0]   rdy2_q;

  // Reset holds every bus quiet; flush squashes the broadcast of its own cycle
  assign wake_en  = ~rst & ~flush;
  assign mc_ready = (state == IDLE) | last;
  assign mc_done  = last;
  assign mc_grant = grant[MC_PORT] & mc_ready;

  // Multi-cycle sequencer; a grant in the final cycle chains straight into a new op
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      last    <= 1'b0;
      lat_tag <= '0;
      lat_v   <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= '0;
      last  <= 1'b0;
    end else if (mc_grant) begin
      state   <= BUSY;
      cnt     <= MC_CNT_W'(1);
      last    <= (LAST_CNT == MC_CNT_W'(1));
      lat_tag <= grant_prd[MC_PORT*PRF_WIDTH +: PRF_WIDTH];
      lat_v   <= grant_prd_v[MC_PORT];
    end else if (state == BUSY) begin
      if (last) begin
        state <= IDLE;
        cnt   <= '0;
        last  <= 1'b0;
      end else begin
        cnt  <= cnt + MC_CNT_W'(1);
        last <= ((cnt + MC_CNT_W'(1)) == LAST_CNT);
      end
    end
  end

  for (genvar p = 0; p < ISSUE_NUM; p++) begin : g_bus
    if (p == MC_PORT) begin : g_mc
      assign wake_v[p] = wake_en & last & lat_v & (lat_tag != '0);
      assign wake_tag[p*PRF_WIDTH +: PRF_WIDTH] = rst ? '0 : lat_tag;
    end else begin : g_fast
      logic [PRF_WIDTH-1:0] prd;
      assign prd       = grant_prd[p*PRF_WIDTH +: PRF_WIDTH];
      assign wake_v[p] = wake_en & grant[p] & grant_prd_v[p] & (prd != '0);
      assign wake_tag[p*PRF_WIDTH +: PRF_WIDTH] = rst ? '0 : prd;
    end
  end

  for (genvar i = 0; i < IQ_DEPTH; i++) begin : g_entry
    logic [PRF_WIDTH-1:0] tag1;
    logic [PRF_WIDTH-1:0] tag2;
    // A freshly allocated entry compares its incoming tags so a same-cycle wake is not lost
    assign tag1 = alloc_v[i] ? alloc_prs1[i*PRF_WIDTH +: PRF_WIDTH] : iq_prs1[i*PRF_WIDTH +: PRF_WIDTH];
    assign tag2 = alloc_v[i] ? alloc_prs2[i*PRF_WIDTH +: PRF_WIDTH] : iq_prs2[i*PRF_WIDTH +: PRF_WIDTH];

    wakeup_match #(
      .ISSUE_NUM (ISSUE_NUM),
      .PRF_WIDTH (PRF_WIDTH)
    ) u_match (
      .wake_v   (wake_v),
      .wake_tag (wake_tag),
      .tag1     (tag1),
      .tag2     (tag2),
      .hit1     (hit1[i]),
      .hit2     (hit2[i])
    );
  end

  // Sticky readiness: loaded on allocation (tag 0 is always ready), set by any hit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy1_q <= '0;
      rdy2_q <= '0;
    end else if (flush) begin
      rdy1_q <= '0;
      rdy2_q <= '0;
    end else begin
      for (int i = 0; i < IQ_DEPTH; i++) begin
        if (alloc_v[i]) begin
          rdy1_q[i] <= alloc_rdy1[i] | hit1[i] | (alloc_prs1[i*PRF_WIDTH +: PRF_WIDTH] == '0);
          rdy2_q[i] <= alloc_rdy2[i] | hit2[i] | (alloc_prs2[i*PRF_WIDTH +: PRF_WIDTH] == '0);
        end else begin
          rdy1_q[i] <= rdy1_q[i] | hit1[i];
          rdy2_q[i] <= rdy2_q[i] | hit2[i];
        end
      end
    end
  end

  // Same-cycle bypass lets a dependent issue back-to-back with its producer
  assign prs1_rdy = rdy1_q | hit1;
  assign prs2_rdy = rdy2_q | hit2;

endmodule
`default_nettype wire
